// File: rtl/router_pkt_src.sv
// Packet source for the router input port: buffers a host-loaded payload, then
// streams header, payload and XOR parity to the router under busy back-pressure.
module router_pkt_src #(
  parameter int MAX_LEN = 63,
  parameter int IFG     = 2
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_dest,
  input  logic [5:0] cmd_len,
  input  logic       cmd_bad_parity,
  output logic       cmd_err,
  input  logic       pl_valid,
  input  logic [7:0] pl_data,
  output logic       pl_ready,
  input  logic       busy,
  output logic       pkt_valid,
  output logic [7:0] data_out,
  output logic       done,
  output logic       tx_active
);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_HEADER, S_PAYLOAD, S_PARITY, S_GAP
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] header_q, header_d;
  logic [5:0] len_q, len_d;
  logic       bad_q, bad_d;
  logic [7:0] parity_q, parity_d;
  logic [5:0] wr_idx_q, wr_idx_d;
  logic [5:0] rd_idx_q, rd_idx_d;
  logic [7:0] gap_q, gap_d;
  logic       cmd_ready_q, cmd_err_q, cmd_err_d;
  logic       done_q, done_d;
  logic       pkt_valid_q, pkt_valid_d;
  logic [7:0] data_out_q, data_out_d;
  logic       wr_en;

  logic [7:0] buf_mem [MAX_LEN];

  // NOTE: every output of this block is assigned a default first, so no path
  // through the case statement leaves a signal unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    header_d  = header_q;
    len_d     = len_q;
    bad_d     = bad_q;
    parity_d  = parity_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    gap_d     = gap_q;
    cmd_err_d = 1'b0;
    done_d    = 1'b0;
    wr_en     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_len == 6'd0 || cmd_dest == 2'd3) begin
            cmd_err_d = 1'b1;
          end else begin
            header_d = {cmd_len, cmd_dest};
            parity_d = {cmd_len, cmd_dest};
            len_d    = cmd_len;
            bad_d    = cmd_bad_parity;
            wr_idx_d = 6'd0;
            rd_idx_d = 6'd0;
            state_d  = S_FILL;
          end
        end
      end
      S_FILL: begin
        if (pl_valid) begin
          wr_en    = 1'b1;
          parity_d = parity_q ^ pl_data;
          wr_idx_d = wr_idx_q + 6'd1;
          if (wr_idx_q == len_q - 6'd1) state_d = S_HEADER;
        end
      end
      S_HEADER: begin
        if (!busy) state_d = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (!busy) begin
          if (rd_idx_q == len_q - 6'd1) state_d = S_PARITY;
          else                          rd_idx_d = rd_idx_q + 6'd1;
        end
      end
      S_PARITY: begin
        if (!busy) begin
          done_d  = 1'b1;
          gap_d   = 8'd0;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_q == 8'(IFG - 1)) state_d = S_IDLE;
        else                      gap_d   = gap_q + 8'd1;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    pkt_valid_d = 1'b0;
    data_out_d  = 8'h00;
    case (state_d)
      S_HEADER: begin
        pkt_valid_d = 1'b1;
        data_out_d  = header_d;
      end
      S_PAYLOAD: begin
        pkt_valid_d = 1'b1;
        data_out_d  = buf_mem[rd_idx_d];
      end
      S_PARITY: data_out_d = parity_d ^ {8{bad_d}};
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      header_q    <= 8'h00;
      len_q       <= 6'd0;
      bad_q       <= 1'b0;
      parity_q    <= 8'h00;
      wr_idx_q    <= 6'd0;
      rd_idx_q    <= 6'd0;
      gap_q       <= 8'd0;
      cmd_ready_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      done_q      <= 1'b0;
      pkt_valid_q <= 1'b0;
      data_out_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      header_q    <= header_d;
      len_q       <= len_d;
      bad_q       <= bad_d;
      parity_q    <= parity_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      gap_q       <= gap_d;
      cmd_ready_q <= (state_d == S_IDLE);
      cmd_err_q   <= cmd_err_d;
      done_q      <= done_d;
      pkt_valid_q <= pkt_valid_d;
      data_out_q  <= data_out_d;
    end
  end

  // NOTE: the payload buffer has no reset; every entry read is written during
  // FILL first, and leaving it unreset lets it map onto plain RAM.
  always_ff @(posedge clock) begin
    if (wr_en) buf_mem[wr_idx_q] <= pl_data;
  end

  assign cmd_ready = cmd_ready_q;
  assign cmd_err   = cmd_err_q;
  assign pl_ready  = (state_q == S_FILL);
  assign pkt_valid = pkt_valid_q;
  assign data_out  = data_out_q;
  assign done      = done_q;
  assign tx_active = (state_q != S_IDLE);

endmodule

// File: tb/tb_router_pkt_src.sv
// Self-checking bench for router_pkt_src: table-driven commands plus directed
// stall, maximum-length, back-to-back and mid-packet reset sequences.
module tb_router_pkt_src;

  localparam int IFG = 2;

  logic       clock, resetn;
  logic       cmd_valid, cmd_ready;
  logic [1:0] cmd_dest;
  logic [5:0] cmd_len;
  logic       cmd_bad_parity, cmd_err;
  logic       pl_valid, pl_ready;
  logic [7:0] pl_data;
  logic       busy, pkt_valid, done, tx_active;
  logic [7:0] data_out;

  router_pkt_src #(.MAX_LEN(63), .IFG(IFG)) dut (
    .clock(clock), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .cmd_bad_parity(cmd_bad_parity), .cmd_err(cmd_err),
    .pl_valid(pl_valid), .pl_data(pl_data), .pl_ready(pl_ready),
    .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out),
    .done(done), .tx_active(tx_active)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]      dest;
    logic [5:0]      len;
    logic            bad;
    logic [3:0][7:0] pl;
    logic            exp_err;
    logic [7:0]      exp_hdr;
    logic [7:0]      exp_par;
  } vec_t;

  vec_t       vecs[6];
  logic [7:0] pl_src[64];
  logic [7:0] ex[80];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: records every byte the router consumes, checks hold-while-busy,
  // the done pulse after parity and the idle gap between packets.
  logic [7:0] rx_q[$];
  int         pkt_count = 0;
  int         low_cnt = 0;
  bit         exp_par, exp_done, hold_valid, hold_pv, gap_track;
  logic [7:0] hold_data;

  always @(negedge clock) begin
    if (!resetn) begin
      exp_par = 0; exp_done = 0; hold_valid = 0; gap_track = 0;
    end else begin
      check("done_pulse", done, exp_done);
      exp_done = 0;
      if (hold_valid) begin
        check("hold_pkt_valid", pkt_valid, hold_pv);
        check("hold_data", data_out, hold_data);
      end
      hold_valid = 0;
      if (pkt_valid && gap_track) begin
        check("ifg_low_ok", low_cnt >= IFG, 1);
        gap_track = 0;
      end
      if (pkt_valid || exp_par) begin
        if (busy) begin
          hold_valid = 1; hold_pv = pkt_valid; hold_data = data_out;
        end else begin
          rx_q.push_back(data_out);
          if (pkt_valid) exp_par = 1;
          else begin
            exp_par = 0; exp_done = 1; pkt_count++; gap_track = 1; low_cnt = 0;
          end
        end
      end else if (gap_track) begin
        low_cnt++;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic issue_cmd(input logic [1:0] d, input logic [5:0] l, input logic b);
    int n = 0;
    while (!cmd_ready && n < 200) begin cyc(); n++; end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1; cmd_dest = d; cmd_len = l; cmd_bad_parity = b;
    cyc();
    cmd_valid = 0;
  endtask

  task automatic fill_bytes(input int n, input bit toggle);
    for (int i = 0; i < n; i++) begin
      if (toggle && (i % 2 == 1)) begin pl_valid = 0; cyc(); end
      if (i == 0) check("pl_ready_fill", pl_ready, 1);
      pl_valid = 1; pl_data = pl_src[i];
      cyc();
    end
    pl_valid = 0;
  endtask

  task automatic wait_pkt(input int target);
    int n = 0;
    while (pkt_count < target && n < 500) begin cyc(); n++; end
    check("pkt_timeout", pkt_count, target);
  endtask

  task automatic compare_rx(input string name, input int n);
    check({name, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++) check(name, rx_q[i], ex[i]);
  endtask

  task automatic apply_vec(input vec_t v);
    issue_cmd(v.dest, v.len, v.bad);
    if (v.exp_err) begin
      check("cmd_err_pulse", cmd_err, 1);
      check("err_pkt_valid", pkt_valid, 0);
      check("err_tx_active", tx_active, 0);
      check("err_data_out", data_out, 0);
      cyc();
      check("cmd_err_clear", cmd_err, 0);
    end else begin
      check("cmd_err_legal", cmd_err, 0);
      check("tx_active_fill", tx_active, 1);
      check("pkt_valid_fill", pkt_valid, 0);
      for (int i = 0; i < int'(v.len); i++) pl_src[i] = v.pl[i];
      fill_bytes(int'(v.len), 0);
      check("hdr_valid", pkt_valid, 1);
      check("hdr_data", data_out, v.exp_hdr);
      for (int i = 0; i < int'(v.len); i++) begin
        cyc();
        check("pl_valid_out", pkt_valid, 1);
        check("pl_data_out", data_out, v.pl[i]);
      end
      cyc();
      check("par_valid", pkt_valid, 0);
      check("par_data", data_out, v.exp_par);
      check("par_no_done", done, 0);
      cyc();
      check("done_set", done, 1);
      check("gap_data", data_out, 0);
      cyc();
      check("done_clear", done, 0);
      check("gap_ready", cmd_ready, 0);
      cyc();
      check("idle_ready", cmd_ready, 1);
      check("idle_tx_active", tx_active, 0);
    end
  endtask

  initial begin
    resetn = 0; cmd_valid = 0; cmd_dest = 0; cmd_len = 0; cmd_bad_parity = 0;
    pl_valid = 0; pl_data = 0; busy = 0;

    vecs[0] = '{dest:2'd1, len:6'd1, bad:1'b0, pl:32'h0000_00A5, exp_err:1'b0, exp_hdr:8'h05, exp_par:8'hA0};
    vecs[1] = '{dest:2'd2, len:6'd4, bad:1'b0, pl:32'h0403_0201, exp_err:1'b0, exp_hdr:8'h12, exp_par:8'h16};
    vecs[2] = '{dest:2'd3, len:6'd2, bad:1'b0, pl:32'h0,         exp_err:1'b1, exp_hdr:8'h00, exp_par:8'h00};
    vecs[3] = '{dest:2'd0, len:6'd0, bad:1'b0, pl:32'h0,         exp_err:1'b1, exp_hdr:8'h00, exp_par:8'h00};
    vecs[4] = '{dest:2'd0, len:6'd2, bad:1'b1, pl:32'h0000_2211, exp_err:1'b0, exp_hdr:8'h08, exp_par:8'hC4};
    vecs[5] = '{dest:2'd2, len:6'd3, bad:1'b0, pl:32'h000F_00FF, exp_err:1'b0, exp_hdr:8'h0E, exp_par:8'hFE};

    #12;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_done", done, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_tx_active", tx_active, 0);
    @(posedge clock); #1;
    resetn = 1;
    cyc();
    check("post_rst_ready", cmd_ready, 1);

    for (int k = 0; k < 6; k++) apply_vec(vecs[k]);

    // Busy stalls at header, mid-payload and parity.
    rx_q.delete();
    busy = 1;
    issue_cmd(2'd2, 6'd4, 1'b0);
    for (int i = 0; i < 4; i++) pl_src[i] = 8'(i + 1);
    fill_bytes(4, 0);
    check("stall_hdr", data_out, 8'h12);
    cyc(); cyc();
    check("stall_hdr_held", data_out, 8'h12);
    busy = 0; cyc();
    check("stall_b0", data_out, 8'h01);
    cyc();
    check("stall_b1", data_out, 8'h02);
    busy = 1; cyc(); cyc();
    check("stall_b1_held", data_out, 8'h02);
    busy = 0; cyc(); cyc(); cyc();
    check("stall_par", data_out, 8'h16);
    busy = 1; cyc();
    check("stall_par_no_done", done, 0);
    busy = 0; cyc();
    check("stall_done", done, 1);
    ex[0] = 8'h12; ex[1] = 8'h01; ex[2] = 8'h02; ex[3] = 8'h03; ex[4] = 8'h04; ex[5] = 8'h16;
    compare_rx("stall_rx", 6);

    // Maximum length with pl_valid toggling during fill.
    rx_q.delete();
    begin
      int base;
      base = pkt_count;
      issue_cmd(2'd0, 6'd63, 1'b0);
      for (int i = 0; i < 63; i++) pl_src[i] = 8'(i);
      fill_bytes(63, 1);
      wait_pkt(base + 1);
    end
    ex[0] = 8'hFC;
    for (int i = 0; i < 63; i++) ex[i + 1] = 8'(i);
    ex[64] = 8'hC3;
    compare_rx("maxlen_rx", 65);

    // Back-to-back packets.
    rx_q.delete();
    begin
      int base;
      base = pkt_count;
      issue_cmd(2'd0, 6'd1, 1'b0);
      pl_src[0] = 8'h3C;
      fill_bytes(1, 0);
      issue_cmd(2'd2, 6'd2, 1'b0);
      pl_src[0] = 8'h55; pl_src[1] = 8'hAA;
      fill_bytes(2, 0);
      wait_pkt(base + 2);
    end
    ex[0] = 8'h04; ex[1] = 8'h3C; ex[2] = 8'h38;
    ex[3] = 8'h0A; ex[4] = 8'h55; ex[5] = 8'hAA; ex[6] = 8'hF5;
    compare_rx("b2b_rx", 7);

    // Reset mid-payload, then a clean packet.
    issue_cmd(2'd1, 6'd4, 1'b0);
    pl_src[0] = 8'h10; pl_src[1] = 8'h20; pl_src[2] = 8'h30; pl_src[3] = 8'h40;
    fill_bytes(4, 0);
    cyc(); cyc();
    check("mid_pl_valid", pkt_valid, 1);
    check("mid_pl_data", data_out, 8'h20);
    resetn = 0;
    #1;
    check("async_pkt_valid", pkt_valid, 0);
    check("async_data_out", data_out, 0);
    check("async_tx_active", tx_active, 0);
    check("async_cmd_ready", cmd_ready, 0);
    check("async_done", done, 0);
    cyc(); cyc();
    check("rst_hold_done", done, 0);
    resetn = 1;
    cyc();
    check("rerst_ready", cmd_ready, 1);
    check("rerst_done", done, 0);
    rx_q.delete();
    apply_vec(vecs[1]);

    cyc(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/router_pkt_src.md
# router_pkt_src

Packet source for the router input port: the transmitting end of the header/payload/parity protocol that the router FSM receives. A host loads a command (destination, length) and streams the payload bytes into an internal buffer. The block then drives `pkt_valid`/`data_out` into the router, holding each byte while the router's `busy` is high, and appends the XOR parity byte. It serves as the stimulus engine for system benches and as the on-chip traffic generator.

## Interface
- `MAX_LEN`, 63: maximum payload bytes; the buffer depth. The length field is 6 bits, so the value is fixed at 63.
- `IFG`, 2: idle cycles (≥1) between a parity acceptance and the next header.
- `clock`  in  1  single clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_dest`  in  2  destination address; 0..2 are legal.
- `cmd_len`  in  6  payload length; 1..63 are legal.
- `cmd_bad_parity`  in  1  transmit the inverted parity (error injection).
- `cmd_err`  out  1  1-cycle pulse when an illegal command is rejected.
- `pl_valid`  in  1  payload byte valid.
- `pl_data`  in  8  payload byte.
- `pl_ready`  out  1  high in FILL.
- `busy`  in  1  router busy; the router is not sampling the current byte.
- `pkt_valid`  out  1  asserted for the header and payload bytes.
- `data_out`  out  8  byte to the router.
- `done`  out  1  1-cycle pulse when the parity byte is accepted.
- `tx_active`  out  1  high in any state other than IDLE.

## Operation
- **States.** IDLE, FILL, HEADER, PAYLOAD, PARITY, GAP.
- **IDLE.**
  - A command is accepted when `cmd_valid` and `cmd_ready` are both high.
  - If `cmd_len==0` or `cmd_dest==3`: pulse `cmd_err` and stay in IDLE.
  - Otherwise latch the header `{cmd_len,cmd_dest}`, `cmd_len` and `cmd_bad_parity`, then go to FILL.
- **FILL.**
  - On each `pl_valid & pl_ready`, write `pl_data` to `buf[wr_idx]` and increment `wr_idx`.
  - Parity accumulates the XOR of the header and every payload byte.
  - When the byte with `wr_idx==len-1` is written, go to HEADER.
- **HEADER.**
  - Drive `pkt_valid=1`, `data_out=header`.
  - Go to PAYLOAD on the first rising edge with `busy==0`.
- **PAYLOAD.**
  - Drive `pkt_valid=1`, `data_out=buf[rd_idx]`.
  - On each edge with `busy==0`, increment `rd_idx`.
  - After byte `len-1` is accepted, go to PARITY.
- **PARITY.**
  - Drive `pkt_valid=0`, `data_out=parity ^ {8{bad_parity}}`.
  - On the edge with `busy==0`, pulse `done` and go to GAP.
- **GAP.** Count `IFG` cycles, then go to IDLE.
- **Transfer rule.** A byte is consumed only on a rising edge where `busy==0` and the state is HEADER, PAYLOAD or PARITY. While `busy==1`, `data_out` and `pkt_valid` hold stable, with no limit on how long `busy` stays high.
- **pkt_valid continuity.** `pkt_valid` stays high without gaps from the header through the last payload byte. The whole payload is therefore buffered before the header is sent.
- **Outside HEADER/PAYLOAD/PARITY.** `pkt_valid=0`, `data_out=8'h00`.
- **Widths.** `wr_idx`/`rd_idx` are 6 bits and never wrap, since `len≤63`. Parity is 8-bit XOR.

## Timing
- **Reset values.** All outputs 0 (`cmd_ready`=0 while `resetn` low, 1 in the first cycle after release). State IDLE, counters and parity 0; buffer contents don't care.
- **Reset mid-packet.** `pkt_valid` drops immediately (asynchronous). No `done` pulse.
- **Registered outputs.** `pkt_valid`, `data_out`, `done` and `cmd_err` are registered: they change only on rising edges, except at reset.
- **Command to header.** Fill time is `len` cycles minimum with `pl_valid` held high. The header appears on the cycle after the last payload write.
- **Zero-stall packet.** With `busy` always low, header, payload and parity occupy `len+2` consecutive cycles. `done` is asserted in the cycle after parity acceptance.
- **busy at HEADER entry.** If `busy` is high on the first HEADER cycle, the header is held until `busy` falls.
- **GAP.** `pkt_valid` stays low for at least `IFG` cycles after the parity byte before the next HEADER. `cmd_ready` rises in the cycle GAP exits.
- **Illegal command.** `cmd_err` is asserted the cycle after acceptance. No other output changes.

## Test plan
- **Minimal packet.** Reset; `cmd_dest=1`, `cmd_len=1`, payload 8'hA5, `busy=0` → `data_out` sequence 8'h05, 8'hA5, 8'hA0 on 3 consecutive cycles; `pkt_valid`=1,1,0; `done` 1 cycle later.
- **busy stalls.** `len=4`, payload 01,02,03,04, `dest=2`; `busy` high 3 cycles during HEADER, 2 cycles mid-payload, 1 cycle at PARITY → each byte held stable, no duplicates or drops; parity = 8'h12^01^02^03^04 = 8'h16.
- **Maximum length with fill stalls.** `len=63`, incrementing payload 0..62, `pl_valid` toggling → header 8'hFC, 63 payload bytes in order, correct XOR parity, `pkt_valid` never dropping mid-payload.
- **Illegal commands and error injection.** `cmd_dest=3` and `cmd_len=0` → `cmd_err` pulse each, `pkt_valid` stays 0. `cmd_bad_parity=1` → parity byte inverted.
- **Back-to-back and reset.**
  - Two packets back-to-back → ≥`IFG` idle cycles between parity and the next header.
  - `resetn` asserted mid-PAYLOAD → `pkt_valid`=0 asynchronously, no `done`.
  - A subsequent packet after reset is correct.
